// File: rtl/output_deskew_pkg.sv
// Shared constants and types for the output deskew stage.
package output_deskew_pkg;

  localparam int INT_WIDTH                = 16;
  localparam int OUTPUT_DESKEW_FIFO_DEPTH = 4;

  // One lane result; a row is LANES of these.
  typedef logic [INT_WIDTH-1:0] lane_t;

endpackage

// File: rtl/deskew_row_fifo.sv
// Row FIFO for aligned wavefronts: first-word fall-through head, level-derived
// full/empty, and push accepted when full only if a pop happens in the same cycle.
module deskew_row_fifo #(
  parameter int WIDTH = 16,
  parameter int LANES = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_async_n_i,
  input  logic                          push,
  input  logic [LANES-1:0][WIDTH-1:0]   push_data,
  input  logic                          pop,
  output logic [LANES-1:0][WIDTH-1:0]   head_data,
  output logic                          not_empty,
  output logic                          full,
  output logic [$clog2(DEPTH+1)-1:0]    level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [LANES-1:0][WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [LW-1:0]               level_q;
  logic                        do_push;
  logic                        do_pop;

  assign full      = (level_q == LW'(DEPTH));
  assign not_empty = (level_q != '0);
  assign do_pop    = pop & not_empty;
  // When full, the write slot equals the head slot; the simultaneous pop frees it.
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];
  assign level     = level_q;

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/output_deskew.sv
// Realigns the diagonal wavefront from the systolic array into row vectors and
// buffers them for a valid/ready consumer. Lane i is delayed LANES-1-i cycles.
// Optional build macro OUTPUT_DESKEW_ERR_CHECK_EN enables the sticky
// misalign/overflow flags; without it the flags read 0 and err_clr_i is ignored.
module output_deskew
  import output_deskew_pkg::*;
#(
  parameter int WIDTH      = INT_WIDTH,
  parameter int LANES      = 8,
  parameter int FIFO_DEPTH = OUTPUT_DESKEW_FIFO_DEPTH
) (
  input  logic                              clk_i,
  input  logic                              rst_async_n_i,
  input  logic [LANES-1:0][WIDTH-1:0]       lane_data_i,
  input  logic [LANES-1:0]                  lane_valid_i,
  output logic [LANES-1:0][WIDTH-1:0]       row_data_o,
  output logic                              row_valid_o,
  input  logic                              row_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
  input  logic                              err_clr_i,
  output logic                              misalign_err_o,
  output logic                              overflow_err_o
);

  logic [LANES-1:0][WIDTH-1:0] dly_data;
  logic [LANES-1:0]            dly_valid;
  logic                        aligned;
  logic                        partial;
  logic                        pop;
  logic                        full;
  logic                        overflow_evt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int DLY = LANES - 1 - i;
    if (DLY == 0) begin : g_pass
      assign dly_data[i]  = lane_data_i[i];
      assign dly_valid[i] = lane_valid_i[i];
    end else begin : g_dly
      logic [WIDTH-1:0] d_q [DLY];
      logic [DLY-1:0]   v_q;

      // Free-running shift line; the array cannot be stalled.
      always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
          for (int k = 0; k < DLY; k++) d_q[k] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= lane_data_i[i];
          v_q[0] <= lane_valid_i[i];
          for (int k = 1; k < DLY; k++) begin
            d_q[k] <= d_q[k-1];
            v_q[k] <= v_q[k-1];
          end
        end
      end

      assign dly_data[i]  = d_q[DLY-1];
      assign dly_valid[i] = v_q[DLY-1];
    end
  end

  assign aligned      = &dly_valid;
  assign partial      = (|dly_valid) & ~aligned;
  assign pop          = row_valid_o & row_ready_i;
  assign overflow_evt = aligned & full & ~pop;

  deskew_row_fifo #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_async_n_i (rst_async_n_i),
    .push          (aligned),
    .push_data     (dly_data),
    .pop           (pop),
    .head_data     (row_data_o),
    .not_empty     (row_valid_o),
    .full          (full),
    .level         (fifo_level_o)
  );

`ifdef OUTPUT_DESKEW_ERR_CHECK_EN
  logic misalign_q;
  logic overflow_q;

  // Sticky flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      misalign_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      misalign_q <= (misalign_q & ~err_clr_i) | partial;
      overflow_q <= (overflow_q & ~err_clr_i) | overflow_evt;
    end
  end

  assign misalign_err_o = misalign_q;
  assign overflow_err_o = overflow_q;
`else
  logic unused_err;
  assign unused_err     = ^{err_clr_i, partial, overflow_evt};
  assign misalign_err_o = 1'b0;
  assign overflow_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_output_deskew.sv
// Scoreboard bench for output_deskew: stimulus schedules wavefronts, a lane-history
// model forms expected rows, and a monitor checks every accepted row in order.
module tb_output_deskew;
  import output_deskew_pkg::*;

  localparam int LANES = 8;
  localparam int DEPTH = 4;
  localparam int W     = INT_WIDTH;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int HIST  = 64;

  typedef logic [LANES-1:0][W-1:0] row_t;

  logic              clk;
  logic              rst_n;
  row_t              lane_data_i;
  logic [LANES-1:0]  lane_valid_i;
  row_t              row_data_o;
  logic              row_valid_o;
  logic              row_ready_i;
  logic [LW-1:0]     fifo_level_o;
  logic              err_clr_i;
  logic              misalign_err_o;
  logic              overflow_err_o;

  output_deskew #(.WIDTH(W), .LANES(LANES), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_async_n_i  (rst_n),
    .lane_data_i    (lane_data_i),
    .lane_valid_i   (lane_valid_i),
    .row_data_o     (row_data_o),
    .row_valid_o    (row_valid_o),
    .row_ready_i    (row_ready_i),
    .fifo_level_o   (fifo_level_o),
    .err_clr_i      (err_clr_i),
    .misalign_err_o (misalign_err_o),
    .overflow_err_o (overflow_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  row_t exp_q[$];
  int   model_level;
  logic model_mis;
  logic model_ovf;
  int   cyc;

  // Upstream schedule (pending) and what actually reached the lanes (history).
  logic         pv [HIST][LANES];
  logic [W-1:0] pd [HIST][LANES];
  logic         hv [HIST][LANES];
  logic [W-1:0] hd [HIST][LANES];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    model_level = 0;
    model_mis   = 1'b0;
    model_ovf   = 1'b0;
    cyc         = HIST;
    for (int s = 0; s < HIST; s++)
      for (int i = 0; i < LANES; i++) begin
        pv[s][i] = 1'b0; pd[s][i] = '0; hv[s][i] = 1'b0; hd[s][i] = '0;
      end
  endtask

  // Wavefront: lane i valid i cycles after lane 0; drop >= 0 withholds that lane.
  task automatic schedule_wf(input int drop, input int base);
    for (int i = 0; i < LANES; i++) begin
      if (i != drop) begin
        pv[(cyc + i) % HIST][i] = 1'b1;
        pd[(cyc + i) % HIST][i] = (base >= 0) ? W'(base + i) : W'($urandom);
      end
    end
  endtask

  task automatic step(input logic start, input int drop, input int base,
                      input logic rdy, input logic clr);
    int   slot;
    int   idx;
    logic all_v;
    logic any_v;
    logic pop_m;
    logic ovf_evt;
    logic mis_evt;
    row_t row;
    @(posedge clk); #1;
    chk("fifo_level", 64'(fifo_level_o), 64'(model_level));
    chk("row_valid", 64'(row_valid_o), 64'(model_level > 0));
    chk("misalign_err", 64'(misalign_err_o), 64'(model_mis));
    chk("overflow_err", 64'(overflow_err_o), 64'(model_ovf));
    if (start) schedule_wf(drop, base);
    slot = cyc % HIST;
    for (int i = 0; i < LANES; i++) begin
      lane_valid_i[i] = pv[slot][i];
      lane_data_i[i]  = pv[slot][i] ? pd[slot][i] : W'($urandom);
      hv[slot][i]     = pv[slot][i];
      hd[slot][i]     = lane_data_i[i];
      pv[slot][i]     = 1'b0;
    end
    row_ready_i = rdy;
    err_clr_i   = clr;
    // Row whose lane 0 entered LANES-1 cycles ago completes in this cycle.
    all_v = 1'b1;
    any_v = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      idx    = (cyc - (LANES - 1) + i) % HIST;
      all_v  = all_v & hv[idx][i];
      any_v  = any_v | hv[idx][i];
      row[i] = hd[idx][i];
    end
    pop_m   = (model_level > 0) && rdy;
    ovf_evt = all_v && (model_level == DEPTH) && !pop_m;
    mis_evt = any_v && !all_v;
    if (all_v && !ovf_evt) begin
      exp_q.push_back(row);
      model_level++;
    end
    if (pop_m) model_level--;
`ifdef OUTPUT_DESKEW_ERR_CHECK_EN
    model_mis = (model_mis && !clr) || mis_evt;
    model_ovf = (model_ovf && !clr) || ovf_evt;
`else
    model_mis = 1'b0;
    model_ovf = 1'b0;
    if (mis_evt && ovf_evt) model_mis = 1'b0;
`endif
    cyc++;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n        = 1'b0;
    lane_valid_i = '0;
    row_ready_i  = 1'b0;
    err_clr_i    = 1'b0;
    #1;
    chk("rst_row_valid", 64'(row_valid_o), 64'(0));
    chk("rst_level", 64'(fifo_level_o), 64'(0));
    chk("rst_row_data_lo", 64'(row_data_o[3:0]), 64'(0));
    chk("rst_row_data_hi", 64'(row_data_o[7:4]), 64'(0));
    chk("rst_flags", 64'({misalign_err_o, overflow_err_o}), 64'(0));
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_model();
  endtask

  // Monitor: every DUT handshake must match the next expected row.
  initial begin : monitor
    row_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && row_valid_o === 1'b1 && row_ready_i === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL row_unexpected: got %h with no row expected at t=%0t", row_data_o, $time);
        end else begin
          e = exp_q.pop_front();
          if (row_data_o !== e) begin
            errors++;
            $display("FAIL row_data: got %h expected %h at t=%0t", row_data_o, e, $time);
          end
        end
      end
    end
  end

  initial begin : stim
    rst_n        = 1'b0;
    lane_data_i  = '0;
    lane_valid_i = '0;
    row_ready_i  = 1'b0;
    err_clr_i    = 1'b0;
    clear_model();
    do_reset(2);

    // Single wavefront 100..107.
    step(1, -1, 100, 1, 0);
    repeat (11) step(0, -1, -1, 1, 0);

    // 16 back-to-back wavefronts.
    repeat (16) step(1, -1, -1, 1, 0);
    repeat (10) step(0, -1, -1, 1, 0);

    // Five wavefronts into a stalled consumer, then drain.
    repeat (5) step(1, -1, -1, 0, 0);
    repeat (10) step(0, -1, -1, 0, 0);
    repeat (8) step(0, -1, -1, 1, 0);
    step(0, -1, -1, 0, 1);

    // Full FIFO with push and pop landing in the same cycle.
    repeat (4) step(1, -1, -1, 0, 0);
    repeat (6) step(0, -1, -1, 0, 0);
    step(1, -1, -1, 0, 0);
    repeat (6) step(0, -1, -1, 0, 0);
    step(0, -1, -1, 1, 0);
    repeat (2) step(0, -1, -1, 0, 0);
    repeat (8) step(0, -1, -1, 1, 0);

    // Lane 3 withheld, then clear, then a clean wavefront.
    step(1, 3, -1, 1, 0);
    repeat (10) step(0, -1, -1, 1, 0);
    step(0, -1, -1, 1, 1);
    step(1, -1, -1, 1, 0);
    repeat (10) step(0, -1, -1, 1, 0);

    // Reset mid-stream with two rows buffered and one wavefront in flight.
    step(1, -1, -1, 0, 0);
    step(1, -1, -1, 0, 0);
    repeat (8) step(0, -1, -1, 0, 0);
    step(1, -1, -1, 0, 0);
    repeat (3) step(0, -1, -1, 0, 0);
    do_reset(2);
    step(1, -1, 200, 1, 0);
    repeat (11) step(0, -1, -1, 1, 0);

    // Randomised traffic.
    for (int n = 0; n < 400; n++)
      step(($urandom % 3) == 0,
           (($urandom % 10) == 0) ? int'($urandom % LANES) : -1,
           -1, ($urandom % 4) != 0, ($urandom % 16) == 0);
    repeat (16) step(0, -1, -1, 1, 0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
